// File: rtl/i4003_loader.sv
// i4003_loader: serial loader for a chain of cascaded i4003 10-bit shift
// registers. Shifts a parallel word out MSB first on sr_data/sr_cp and
// captures the previous chain contents from sr_sin as they fall out.
module i4003_loader #(
  parameter int  N_DEV = 1,
  parameter int  DIV   = 2,
  parameter int  BLANK = 1,
  localparam int W     = 10 * N_DEV
) (
  input  logic         cp,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] rdata,
  output logic         sr_cp,
  output logic         sr_data,
  output logic         sr_e,
  input  logic         sr_sin
);

  localparam int            JW     = $clog2(W);
  localparam int            DW     = $clog2(DIV);
  localparam logic [JW-1:0] J_LAST = JW'(W - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  shift_q, shift_d;
  logic [W-1:0]  rdata_q, rdata_d;
  logic [JW-1:0] bit_q, bit_d;
  logic [DW-1:0] div_q, div_d;
  logic          sr_cp_q, sr_cp_d;
  logic          sr_data_q, sr_data_d;
  logic          sr_e_q, sr_e_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [JW-1:0] rd_idx;

  // Bit j of the transfer lands in rdata[W-1-j] (chain MSB comes out first).
  assign rd_idx = J_LAST - bit_q;

  // Next-state logic for the sequencer; every output is a registered flop.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    rdata_d   = rdata_q;
    bit_d     = bit_q;
    div_d     = div_q;
    sr_cp_d   = sr_cp_q;
    sr_data_d = sr_data_q;
    sr_e_d    = sr_e_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // First bit goes straight onto sr_data; the rest wait in shift_q.
          shift_d   = {wdata[W-2:0], 1'b0};
          sr_data_d = wdata[W-1];
          bit_d     = '0;
          div_d     = '0;
          busy_d    = 1'b1;
          if (BLANK != 0) sr_e_d = 1'b0;
          state_d   = S_LOW;
        end
      end
      S_LOW: begin
        if (div_q == D_LAST) begin
          // The delay latch still shows the pre-shift chain MSB here.
          rdata_d[rd_idx] = sr_sin;
          div_d           = '0;
          sr_cp_d         = 1'b1;
          state_d         = S_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HIGH: begin
        if (div_q == D_LAST) begin
          div_d   = '0;
          sr_cp_d = 1'b0;
          if (bit_q != J_LAST) begin
            bit_d     = bit_q + 1'b1;
            sr_data_d = shift_q[W-1];
            shift_d   = {shift_q[W-2:0], 1'b0};
            state_d   = S_LOW;
          end else begin
            done_d  = 1'b1;
            sr_e_d  = 1'b1;
            state_d = S_DONE;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge cp) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      rdata_q   <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      sr_cp_q   <= 1'b0;
      sr_data_q <= 1'b0;
      sr_e_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      rdata_q   <= rdata_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      sr_cp_q   <= sr_cp_d;
      sr_data_q <= sr_data_d;
      sr_e_q    <= sr_e_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rdata   = rdata_q;
  assign sr_cp   = sr_cp_q;
  assign sr_data = sr_data_q;
  assign sr_e    = sr_e_q;

endmodule
